// File: rtl/sdio_pkg.sv
// Shared definitions for the sdio_top control-port masters: register map,
// status bits, command encodings and the block-read sequencer states.
package sdio_pkg;

    localparam logic [2:0]  ADR_CMD    = 3'd0;
    localparam logic [2:0]  ADR_ARG    = 3'd1;
    localparam logic [2:0]  ADR_FIFO   = 3'd2;

    localparam int          BUSY_BIT   = 14;
    localparam int          ERR_BIT    = 15;

    // CMD17 (single block read), R1 response, data phase from card.
    localparam logic [31:0] CMD17_WORD = 32'h0000_0951;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ARG,
        ST_WR_CMD,
        ST_POLL,
        ST_RD_FIFO,
        ST_STREAM,
        ST_FINISH
    } seq_state_t;

    // Width of a counter that indexes every bus word in one block.
    function automatic int word_cnt_width(input int lgblk, input int mw);
        return lgblk - $clog2(mw / 8);
    endfunction

endpackage

// File: rtl/sdio_wbreq.sv
// Single-outstanding Wishbone master: turns a one-cycle request into one
// bus transaction and returns a one-cycle ack with the read data.
module sdio_wbreq #(
    parameter int MW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          req_we,
    input  logic [2:0]    req_addr,
    input  logic [MW-1:0] req_data,
    output logic          ack,
    output logic [MW-1:0] rdata,
    output logic          wb_cyc,
    output logic          wb_stb,
    output logic          wb_we,
    output logic [2:0]    wb_addr,
    output logic [MW-1:0] wb_data,
    input  logic          wb_stall,
    input  logic          wb_ack,
    input  logic [MW-1:0] wb_rdata
);

    // An ack counts only inside a cycle, and only once the strobe has been
    // (or is being) accepted; this also covers ack-with-acceptance.
    logic complete;
    assign complete = wb_cyc && wb_ack && (!wb_stb || !wb_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_cyc  <= 1'b0;
            wb_stb  <= 1'b0;
            wb_we   <= 1'b0;
            wb_addr <= '0;
            wb_data <= '0;
            ack     <= 1'b0;
            rdata   <= '0;
        end else begin
            ack <= 1'b0;
            if (!wb_cyc) begin
                if (req) begin
                    wb_cyc  <= 1'b1;
                    wb_stb  <= 1'b1;
                    wb_we   <= req_we;
                    wb_addr <= req_addr;
                    wb_data <= req_data;
                end
            end else if (complete) begin
                wb_cyc <= 1'b0;
                wb_stb <= 1'b0;
                ack    <= 1'b1;
                rdata  <= wb_rdata;
            end else if (wb_stb && !wb_stall) begin
                wb_stb <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdio_blkrd_seq.sv
// Single-block read sequencer for sdio_top: writes ARG and CMD17, polls
// status until idle, then streams the block out of the data FIFO.
module sdio_blkrd_seq #(
    parameter int          MW       = 32,
    parameter int          LGBLK    = 9,
    parameter logic [2:0]  ADR_CMD  = sdio_pkg::ADR_CMD,
    parameter logic [2:0]  ADR_ARG  = sdio_pkg::ADR_ARG,
    parameter logic [2:0]  ADR_FIFO = sdio_pkg::ADR_FIFO,
    parameter logic [31:0] CMD_WORD = sdio_pkg::CMD17_WORD,
    parameter int          BUSY_BIT = sdio_pkg::BUSY_BIT,
    parameter int          ERR_BIT  = sdio_pkg::ERR_BIT,
    parameter int          LGPOLL   = 20
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [31:0]     i_sector,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_err,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [2:0]      o_wb_addr,
    output logic [MW-1:0]   o_wb_data,
    output logic [MW/8-1:0] o_wb_sel,
    input  logic            i_wb_stall,
    input  logic            i_wb_ack,
    input  logic [MW-1:0]   i_wb_data,
    output logic            M_VALID,
    input  logic            M_READY,
    output logic [MW-1:0]   M_DATA,
    output logic            M_LAST
);
    import sdio_pkg::*;

    localparam int                WCNT_W = word_cnt_width(LGBLK, MW);
    localparam logic [WCNT_W-1:0] WLAST  = '1;
    localparam logic [LGPOLL-1:0] PMAX   = '1;

    seq_state_t        state;
    logic              req;
    logic              req_we;
    logic [2:0]        req_addr;
    logic [MW-1:0]     req_data;
    logic              ack;
    logic [MW-1:0]     rdata;
    logic [WCNT_W-1:0] wcnt;
    logic [LGPOLL-1:0] pcnt;

    function automatic logic [LGPOLL-1:0] poll_inc(input logic [LGPOLL-1:0] c);
        return (c == PMAX) ? c : c + LGPOLL'(1);
    endfunction

    assign o_wb_sel = '1;

    sdio_wbreq #(
        .MW(MW)
    ) u_wbreq (
        .clk      (i_clk),
        .rst      (i_reset),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_data (req_data),
        .ack      (ack),
        .rdata    (rdata),
        .wb_cyc   (o_wb_cyc),
        .wb_stb   (o_wb_stb),
        .wb_we    (o_wb_we),
        .wb_addr  (o_wb_addr),
        .wb_data  (o_wb_data),
        .wb_stall (i_wb_stall),
        .wb_ack   (i_wb_ack),
        .wb_rdata (i_wb_data)
    );

    // req is a one-cycle pulse; the engine only honours it between cycles,
    // which guarantees the idle gap on cyc between consecutive requests.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            req      <= 1'b0;
            req_we   <= 1'b0;
            req_addr <= '0;
            req_data <= '0;
            wcnt     <= '0;
            pcnt     <= '0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_err    <= 1'b0;
            M_VALID  <= 1'b0;
            M_LAST   <= 1'b0;
            M_DATA   <= '0;
        end else begin
            req    <= 1'b0;
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state    <= ST_WR_ARG;
                        o_busy   <= 1'b1;
                        o_err    <= 1'b0;
                        wcnt     <= '0;
                        req      <= 1'b1;
                        req_we   <= 1'b1;
                        req_addr <= ADR_ARG;
                        req_data <= MW'(i_sector);
                    end
                end
                ST_WR_ARG: begin
                    if (ack) begin
                        state    <= ST_WR_CMD;
                        req      <= 1'b1;
                        req_we   <= 1'b1;
                        req_addr <= ADR_CMD;
                        req_data <= MW'(CMD_WORD);
                    end
                end
                ST_WR_CMD: begin
                    if (ack) begin
                        state    <= ST_POLL;
                        pcnt     <= '0;
                        req      <= 1'b1;
                        req_we   <= 1'b0;
                        req_addr <= ADR_CMD;
                    end
                end
                ST_POLL: begin
                    if (ack) begin
                        if (rdata[ERR_BIT]) begin
                            state  <= ST_FINISH;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                            o_err  <= 1'b1;
                        end else if (rdata[BUSY_BIT]) begin
                            if (pcnt == PMAX) begin
                                state  <= ST_FINISH;
                                o_done <= 1'b1;
                                o_busy <= 1'b0;
                                o_err  <= 1'b1;
                            end else begin
                                pcnt <= poll_inc(pcnt);
                                req  <= 1'b1;
                            end
                        end else begin
                            state    <= ST_RD_FIFO;
                            req      <= 1'b1;
                            req_addr <= ADR_FIFO;
                        end
                    end
                end
                ST_RD_FIFO: begin
                    if (ack) begin
                        state   <= ST_STREAM;
                        M_DATA  <= rdata;
                        M_VALID <= 1'b1;
                        M_LAST  <= (wcnt == WLAST);
                    end
                end
                ST_STREAM: begin
                    if (M_READY) begin
                        M_VALID <= 1'b0;
                        M_LAST  <= 1'b0;
                        if (wcnt == WLAST) begin
                            state  <= ST_FINISH;
                            o_done <= 1'b1;
                            o_busy <= 1'b0;
                        end else begin
                            wcnt  <= wcnt + WCNT_W'(1);
                            state <= ST_RD_FIFO;
                            req   <= 1'b1;
                        end
                    end
                end
                ST_FINISH: begin
                    state <= ST_IDLE;
                    o_err <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdio_blkrd_seq.sv
// Bench for sdio_blkrd_seq: a behavioural sdio_top slave and stream sink
// with randomized stall/ready, checked against transaction-level expectations.
module tb_sdio_blkrd_seq;

    localparam int          MW     = 32;
    localparam int          NW     = 128;
    localparam int          LGPOLL = 4;
    localparam int          NPOLL  = 16;
    localparam logic [2:0]  A_CMD  = 3'd0;
    localparam logic [2:0]  A_ARG  = 3'd1;
    localparam logic [2:0]  A_FIFO = 3'd2;
    localparam logic [31:0] CMDW   = 32'h0000_0951;

    typedef struct packed { logic we; logic [2:0] a; logic [31:0] d; } tr_t;
    typedef struct packed { logic [31:0] d; logic l; } sw_t;

    logic          clk;
    logic          rst;
    logic          i_start;
    logic [31:0]   i_sector;
    logic          o_busy, o_done, o_err;
    logic          o_wb_cyc, o_wb_stb, o_wb_we;
    logic [2:0]    o_wb_addr;
    logic [MW-1:0] o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall, i_wb_ack;
    logic [MW-1:0] i_wb_data;
    logic          M_VALID, M_READY, M_LAST;
    logic [MW-1:0] M_DATA;

    int checks = 0;
    int errors = 0;

    tr_t         log_q[$];
    tr_t         exp_q[$];
    sw_t         stream_q[$];
    logic [31:0] block [NW];
    int          busy_polls, err_at, polls, fidx, ready_mode;
    bit          stall_en, stray_en;
    int          stb_viol, data_viol, valid_seen, done_cnt, hold_cnt;

    sdio_blkrd_seq #(.MW(MW), .LGBLK(9), .LGPOLL(LGPOLL)) dut (
        .i_clk(clk), .i_reset(rst), .i_start(i_start), .i_sector(i_sector),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
        .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack), .i_wb_data(i_wb_data),
        .M_VALID(M_VALID), .M_READY(M_READY), .M_DATA(M_DATA), .M_LAST(M_LAST)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sdio_top register behaviour: status is busy for busy_polls reads, error from read err_at.
    task automatic bus_access(input logic we, input logic [2:0] a, input logic [31:0] d,
                              output logic [31:0] r);
        tr_t t;
        t.we = we; t.a = a; t.d = we ? d : 32'h0;
        log_q.push_back(t);
        r = $urandom;
        if (!we && a == A_CMD) begin
            polls++;
            r[15:14] = 2'b00;
            if (err_at != 0 && polls >= err_at) r[15] = 1'b1;
            else if (polls <= busy_polls)       r[14] = 1'b1;
        end else if (!we && a == A_FIFO) begin
            if (fidx < NW) r = block[fidx];
            fidx++;
        end
    endtask

    initial begin : slave
        bit          pending, held;
        logic [31:0] resp, h_data;
        logic [2:0]  h_addr;
        logic        h_we;
        pending = 0; held = 0; resp = 0; h_data = 0; h_addr = 0; h_we = 0;
        i_wb_stall = 0; i_wb_ack = 0; i_wb_data = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 0; held = 0; i_wb_ack = 0; i_wb_stall = 0;
            end else begin
                if (held && !(o_wb_stb && o_wb_addr == h_addr && o_wb_we == h_we && o_wb_data == h_data))
                    stb_viol++;
                i_wb_ack = 0;
                held = 0;
                if (pending) begin
                    i_wb_ack = 1; i_wb_data = resp; pending = 0;
                    i_wb_stall = stall_en ? 1'($urandom % 2) : 1'b0;
                end else if (o_wb_stb) begin
                    i_wb_stall = stall_en ? ($urandom_range(0, 2) != 0) : 1'b0;
                    if (i_wb_stall) begin
                        held = 1; h_addr = o_wb_addr; h_we = o_wb_we; h_data = o_wb_data;
                    end else begin
                        bus_access(o_wb_we, o_wb_addr, o_wb_data, resp);
                        if ($urandom % 2 == 0) begin i_wb_ack = 1; i_wb_data = resp; end
                        else pending = 1;
                    end
                end else begin
                    i_wb_stall = stall_en ? 1'($urandom % 2) : 1'b0;
                    if (!o_wb_cyc && stray_en && $urandom % 6 == 0) begin
                        i_wb_ack = 1; i_wb_data = $urandom;
                    end
                end
            end
        end
    end

    initial begin : sink
        bit          vheld;
        logic [31:0] h_d;
        logic        h_l;
        sw_t         w;
        vheld = 0; h_d = 0; h_l = 0; M_READY = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                M_READY = 0; vheld = 0;
            end else begin
                if (o_done) done_cnt++;
                if (vheld && (!M_VALID || M_DATA !== h_d || M_LAST !== h_l)) data_viol++;
                if (M_VALID) valid_seen++;
                case (ready_mode)
                    0: M_READY = 1;
                    1: M_READY = 1'($urandom % 2);
                    default: begin
                        if (M_VALID && stream_q.size() == 5 && hold_cnt < 10) begin
                            M_READY = 0; hold_cnt++;
                        end else M_READY = 1'($urandom % 2);
                    end
                endcase
                vheld = 0;
                if (M_VALID && M_READY) begin
                    w.d = M_DATA; w.l = M_LAST; stream_q.push_back(w);
                end else if (M_VALID) begin
                    vheld = 1; h_d = M_DATA; h_l = M_LAST;
                end
            end
        end
    end

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_model();
        log_q.delete(); stream_q.delete();
        polls = 0; fidx = 0; hold_cnt = 0;
        stb_viol = 0; data_viol = 0; valid_seen = 0;
        for (int i = 0; i < NW; i++) block[i] = $urandom;
    endtask

    task automatic make_exp(input logic [31:0] sec, input int np, input int nf);
        exp_q.delete();
        exp_q.push_back({1'b1, A_ARG, sec});
        exp_q.push_back({1'b1, A_CMD, CMDW});
        for (int i = 0; i < np; i++) exp_q.push_back({1'b0, A_CMD, 32'h0});
        for (int i = 0; i < nf; i++) exp_q.push_back({1'b0, A_FIFO, 32'h0});
    endtask

    task automatic do_start(input logic [31:0] sec);
        @(negedge clk);
        i_start = 1; i_sector = sec;
        @(negedge clk);
        i_start = 0; i_sector = $urandom;
    endtask

    task automatic wait_done(input int budget, output bit got, output logic e);
        got = 0; e = 0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (o_done === 1'b1) begin got = 1; e = o_err; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
             M_VALID, M_LAST, M_DATA} !== '0)
            $display("FAIL reset_outputs got busy=%b cyc=%b stb=%b addr=%0h data=%0h mv=%b md=%0h want all 0",
                     o_busy, o_wb_cyc, o_wb_stb, o_wb_addr, o_wb_data, M_VALID, M_DATA);
        checks++;
        if (o_wb_sel !== 4'hF) begin
            errors++; $display("FAIL wb_sel got %0h want f", o_wb_sel);
        end
        rst = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({o_busy, o_done, o_wb_cyc, M_VALID} !== 4'b0) begin
            errors++; $display("FAIL idle_after_reset got %b want 0000", {o_busy, o_done, o_wb_cyc, M_VALID});
        end
    endtask

    task automatic test_normal();
        bit got; logic e;
        clear_model();
        busy_polls = 3; err_at = 0; stall_en = 0; stray_en = 0; ready_mode = 0;
        do_start(32'h0000_1234);
        wait_done(8000, got, e);
        checks++;
        if (!got) begin errors++; $display("FAIL normal_done got 0 want 1"); end
        checks++;
        if (e !== 1'b0 || o_busy !== 1'b0) begin
            errors++; $display("FAIL normal_err_busy got err=%b busy=%b want 0 0", e, o_busy);
        end
        make_exp(32'h0000_1234, 4, NW);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++; $display("FAIL normal_txn_count got %0d want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL normal_txn[%0d] got %0h want %0h", i, log_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stream_q.size() != NW) begin
            errors++; $display("FAIL normal_words got %0d want %0d", stream_q.size(), NW);
        end
        for (int i = 0; i < NW && i < stream_q.size(); i++) begin
            sw_t ew;
            ew.d = block[i]; ew.l = (i == NW - 1);
            checks++;
            if (stream_q[i] !== ew) begin
                errors++; $display("FAIL normal_word[%0d] got %0h want %0h", i, stream_q[i], ew);
            end
        end
    endtask

    task automatic test_error();
        bit got; logic e;
        clear_model();
        err_at = $urandom_range(1, 3); busy_polls = 5; stall_en = 1; stray_en = 1; ready_mode = 0;
        do_start($urandom);
        wait_done(2000, got, e);
        checks++;
        if (!got || e !== 1'b1) begin
            errors++; $display("FAIL error_done got done=%b err=%b want 1 1", got, e);
        end
        checks++;
        if (log_q.size() != 2 + err_at) begin
            errors++; $display("FAIL error_txn_count got %0d want %0d", log_q.size(), 2 + err_at);
        end
        checks++;
        if (valid_seen != 0) begin
            errors++; $display("FAIL error_no_stream got %0d valid cycles want 0", valid_seen);
        end
    endtask

    task automatic test_timeout();
        bit got; logic e; logic [31:0] s;
        clear_model();
        s = $urandom;
        err_at = 0; busy_polls = 1_000_000; stall_en = 0; stray_en = 0; ready_mode = 0;
        do_start(s);
        wait_done(4000, got, e);
        checks++;
        if (!got || e !== 1'b1) begin
            errors++; $display("FAIL timeout_done got done=%b err=%b want 1 1", got, e);
        end
        make_exp(s, NPOLL, 0);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++; $display("FAIL timeout_polls got %0d txns want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL timeout_txn[%0d] got %0h want %0h", i, log_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit got; logic e; logic [31:0] s; int np;
        clear_model();
        s = $urandom; np = $urandom_range(0, 5);
        err_at = 0; busy_polls = np; stall_en = 1; stray_en = 1; ready_mode = 2;
        do_start(s);
        wait_done(20000, got, e);
        checks++;
        if (!got || e !== 1'b0) begin
            errors++; $display("FAIL bp_done got done=%b err=%b want 1 0", got, e);
        end
        make_exp(s, np + 1, NW);
        checks++;
        if (log_q.size() != exp_q.size()) begin
            errors++; $display("FAIL bp_txn_count got %0d want %0d", log_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_txn[%0d] got %0h want %0h", i, log_q[i], exp_q[i]);
            end
        end
        checks++;
        if (stream_q.size() != NW) begin
            errors++; $display("FAIL bp_words got %0d want %0d", stream_q.size(), NW);
        end
        for (int i = 0; i < NW && i < stream_q.size(); i++) begin
            sw_t ew;
            ew.d = block[i]; ew.l = (i == NW - 1);
            checks++;
            if (stream_q[i] !== ew) begin
                errors++; $display("FAIL bp_word[%0d] got %0h want %0h", i, stream_q[i], ew);
            end
        end
        checks++;
        if (stb_viol != 0) begin errors++; $display("FAIL bp_stb_hold got %0d violations want 0", stb_viol); end
        checks++;
        if (data_viol != 0) begin errors++; $display("FAIL bp_data_stable got %0d violations want 0", data_viol); end
        checks++;
        if (hold_cnt != 10) begin errors++; $display("FAIL bp_ready_hold got %0d want 10", hold_cnt); end
    endtask

    task automatic test_start_busy_reset();
        bit got, reached; logic e; logic [31:0] sa, sb, sc; int dc, nargs;
        clear_model();
        sa = $urandom; sb = ~sa;
        err_at = 0; busy_polls = 2; stall_en = 1; stray_en = 1; ready_mode = 1;
        do_start(sa);
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin errors++; $display("FAIL sb_busy got %b want 1", o_busy); end
        do_start(sb);
        reached = 0;
        for (int n = 0; n < 8000; n++) begin
            if (M_VALID === 1'b1 && stream_q.size() >= 40) begin reached = 1; break; end
            @(negedge clk);
        end
        checks++;
        if (!reached) begin errors++; $display("FAIL sb_reach_word40 got 0 want 1"); end
        nargs = 0;
        foreach (log_q[i]) if (log_q[i].we && log_q[i].a == A_ARG) nargs++;
        checks++;
        if (log_q.size() == 0 || log_q[0] !== {1'b1, A_ARG, sa} || nargs != 1) begin
            errors++; $display("FAIL sb_ignored got first=%0h args=%0d want %0h 1",
                               log_q.size() ? log_q[0] : tr_t'(0), nargs, {1'b1, A_ARG, sa});
        end
        dc = done_cnt;
        rst = 1;
        #1;
        checks++;
        if ({o_busy, o_done, o_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data,
             M_VALID, M_LAST, M_DATA} !== '0) begin
            errors++; $display("FAIL midreset_async got cyc=%b stb=%b busy=%b mv=%b want 0",
                               o_wb_cyc, o_wb_stb, o_busy, M_VALID);
        end
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt != dc || o_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_no_done got dones=%0d busy=%b want %0d 0", done_cnt, o_busy, dc);
        end
        clear_model();
        sc = $urandom;
        busy_polls = 1; stall_en = 0; stray_en = 0; ready_mode = 0;
        do_start(sc);
        wait_done(8000, got, e);
        checks++;
        if (!got || e !== 1'b0) begin
            errors++; $display("FAIL rerun_done got done=%b err=%b want 1 0", got, e);
        end
        make_exp(sc, 2, NW);
        checks++;
        if (log_q.size() != exp_q.size() || (log_q.size() > 0 && log_q[0] !== exp_q[0])) begin
            errors++; $display("FAIL rerun_txns got %0d want %0d", log_q.size(), exp_q.size());
        end
        checks++;
        if (stream_q.size() != NW) begin
            errors++; $display("FAIL rerun_words got %0d want %0d", stream_q.size(), NW);
        end
        for (int i = 0; i < NW && i < stream_q.size(); i++) begin
            sw_t ew;
            ew.d = block[i]; ew.l = (i == NW - 1);
            checks++;
            if (stream_q[i] !== ew) begin
                errors++; $display("FAIL rerun_word[%0d] got %0h want %0h", i, stream_q[i], ew);
            end
        end
    endtask

    initial begin
        rst = 1; i_start = 0; i_sector = 0;
        busy_polls = 0; err_at = 0; polls = 0; fidx = 0; ready_mode = 0;
        stall_en = 0; stray_en = 0;
        stb_viol = 0; data_viol = 0; valid_seen = 0; done_cnt = 0; hold_cnt = 0;
        test_reset();
        test_normal();
        test_error();
        test_timeout();
        test_backpressure();
        test_start_busy_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
